hall_position_decoder: RTL and testbench
========================================

# hall_position_decoder

Second-generation Hall-sensor decoder for the BLDC motor path: synchronises and deglitches the three Hall inputs, decodes sector and rotation direction, and keeps a loadable signed position count. It measures the step period between consecutive same-direction transitions, and detects stall, invalid Hall codes and skipped sectors. Outputs feed the commutation and speed-control logic directly.

## Interface
- `clk_freq_hz`, 27_000_000: clock frequency, Hz
- `counter_width`, 32: position counter width, two's complement
- `period_width`, 24: step-period measurement width
- `filter_cycles`, 4: consecutive stable cycles required to accept a Hall code; must be ≥1
- `idle_ms`, 100: no-step time before stall is declared; `idle_ticks = clk_freq_hz/1000*idle_ms` must be < 2^period_width, otherwise elaboration error
- `sys_clk` in 1: clock
- `reset_n` in 1: synchronous, active-low reset
- `hall_values` in 3 (`hall_states_t`): raw Hall inputs {A,B,C}, asynchronous
- `clear_fault` in 1: clears `fault_invalid`
- `pos_load` in 1: load `position` from `pos_load_value`
- `pos_load_value` in `counter_width`: value loaded into `position`
- `sector` out 3: decoded sector 0..5; 7 = unknown or invalid
- `rotation_direction` out 2 (`rotation_direction_t`): DIR_NONE / DIR_CW / DIR_CCW
- `position` out `counter_width`: +1 per CW step, −1 per CCW step, wraps
- `step` out 1: one-cycle pulse per accepted ±1 step
- `period` out `period_width`: cycles between the last two same-direction steps; all-ones = unknown or stalled
- `period_valid` out 1: one-cycle pulse when `period` is updated with a measurement
- `stalled` out 1: high while no motion is established
- `fault_invalid` out 1: sticky flag; an invalid code (000 or 111) was accepted
- `skip_count` out 8: saturating count of skipped-sector transitions

## Operation
- Code map (A,B,C): 101→0, 100→1, 110→2, 010→3, 011→4, 001→5.
- A CW step is sector+1 mod 6; a CCW step is sector−1 mod 6. A jump of ±2 or 3 sectors is a skip.
- Input path: 2-flop synchroniser, then glitch filter. The candidate code is accepted once it has been equal for `filter_cycles` consecutive cycles. Only a change in the accepted code is an event.
- States:
  - INIT: no valid sector known.
  - STALLED: sector known, direction DIR_NONE.
  - RUNNING: direction established.
- INIT + valid code → `sector` set, no `step`, go to STALLED.
- Any state + invalid code → `sector` = 7, `fault_invalid` = 1, direction DIR_NONE, `stalled` = 1, go to INIT. The next valid code re-seeds the sector without a step.
- STALLED/RUNNING + ±1 step:
  - `step` pulses, `position` ±1, direction set, go to RUNNING.
  - `period_valid` pulses only if the previous step was in the same direction and the state was RUNNING. `period` then takes the period counter value.
  - The period counter resets to 1 on every step.
- Direction reversal in RUNNING: the step is counted, direction flips, and there is no `period_valid`.
- Skip: `sector` is updated, `skip_count` +1 (saturates at 255), no step, direction DIR_NONE, period counter reset, go to STALLED.
- Period counter: increments every cycle and saturates at all-ones.
  - When it reaches `idle_ticks` in RUNNING: go to STALLED, direction DIR_NONE, `stalled` = 1, `period` = all-ones, no `period_valid`.
- `pos_load` and a step in the same cycle: load wins and the step delta is discarded. `step` still pulses.
- `clear_fault` and an invalid code accepted in the same cycle: the fault stays set.

## Timing
- Reset values:
  - `sector` = 7, `rotation_direction` = DIR_NONE, `position` = 0
  - `step` = 0, `period` = all-ones, `period_valid` = 0
  - `stalled` = 1, `fault_invalid` = 0, `skip_count` = 0
  - state INIT; filter and synchroniser cleared to 111 with no event generated
- Latency: a stable code change first sampled at edge N is reflected on all outputs after edge N+2+`filter_cycles` (2 sync + filter + output register). All outputs are registered.
- Reset mid-operation: reset takes priority; all state returns to reset values at the next edge.
- The `pos_load` effect is visible one cycle after the load edge.
- Glitch rule: a pulse shorter than `filter_cycles` cycles at the synchroniser output produces no event.

## Structure
- Shared package (existing bldc types):
  - `hall_states_t`, `rotation_direction_t`
  - code-to-sector function
  - `next()`/`prev()` helpers
- Local to the block: state enum, `idle_ticks` localparam.
- Sub-module `hall_input_filter`: synchroniser plus `filter_cycles` stability counter. Outputs the accepted code and a one-cycle `changed` strobe.

## Test plan
- Reset, then apply 101 held steady → after 2+4 cycles `sector` = 0, no `step`, `stalled` = 1, `position` = 0.
- CW sequence 101,100,110,010,011,001,101, each held 1000 cycles → 6 steps, `position` = 6, DIR_CW, `period` = 1000 with `period_valid` on steps 2..6.
- CW then a reversal to CCW → `position` decrements, no `period_valid` on the reversal step, `period_valid` on the next CCW step.
- 2-cycle glitch on B with `filter_cycles` = 4 → no output change. Then 000 held → `sector` = 7, `fault_invalid` = 1; `clear_fault` → 0.
- Jump 101→110 → `skip_count` = 1, no step, DIR_NONE, `sector` = 2.
- No transition for `idle_ticks` while RUNNING → `stalled` = 1, DIR_NONE, `period` = all-ones. `pos_load` = 1 with value −5 coincident with a CW step → `position` = −5.

Source files
------------

// File: rtl/hall_position_decoder_pkg.sv
// Shared BLDC Hall types plus the code-to-sector map and sector stepping helpers.
package hall_position_decoder_pkg;

  typedef logic [2:0] hall_states_t;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_CW   = 2'd1,
    DIR_CCW  = 2'd2
  } rotation_direction_t;

  localparam logic [2:0] SECTOR_UNKNOWN = 3'd7;

  // 000 and 111 are physically impossible codes and decode to the unknown sector.
  function automatic logic [2:0] hall_to_sector(hall_states_t h);
    case (h)
      3'b101:  return 3'd0;
      3'b100:  return 3'd1;
      3'b110:  return 3'd2;
      3'b010:  return 3'd3;
      3'b011:  return 3'd4;
      3'b001:  return 3'd5;
      default: return SECTOR_UNKNOWN;
    endcase
  endfunction

  function automatic logic [2:0] next_sector(logic [2:0] s);
    return (s == 3'd5) ? 3'd0 : s + 3'd1;
  endfunction

  function automatic logic [2:0] prev_sector(logic [2:0] s);
    return (s == 3'd0) ? 3'd5 : s - 3'd1;
  endfunction

endpackage

// File: rtl/hall_position_decoder_input_filter.sv
// Two-flop synchroniser plus stability filter; strobes changed_o when a new code is accepted.
module hall_input_filter
  import hall_position_decoder_pkg::*;
#(
  parameter int filter_cycles = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  hall_states_t hall_i,
  output hall_states_t code_o,
  output logic         changed_o
);

  localparam int CNT_W = $clog2(filter_cycles + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(filter_cycles);

  if (filter_cycles < 1) begin : g_chk_filter
    $error("hall_input_filter: filter_cycles must be at least 1");
  end

  hall_states_t     sync1_q, sync2_q, prev_q, acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             chg_q, chg_d;

  // cnt_d is how many consecutive cycles sync2_q has held its present value.
  always_comb begin
    cnt_d = cnt_q;
    acc_d = acc_q;
    chg_d = 1'b0;
    if (sync2_q != prev_q) begin
      cnt_d = CNT_W'(1);
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (cnt_d == CNT_MAX && sync2_q != acc_q) begin
      acc_d = sync2_q;
      chg_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1_q <= 3'b111;
      sync2_q <= 3'b111;
      prev_q  <= 3'b111;
      acc_q   <= 3'b111;
      cnt_q   <= CNT_MAX;
      chg_q   <= 1'b0;
    end else begin
      sync1_q <= hall_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      chg_q   <= chg_d;
    end
  end

  assign code_o    = acc_q;
  assign changed_o = chg_q;

endmodule

// File: rtl/hall_position_decoder.sv
// Hall decoder: sector/direction tracking, signed position, step period, stall/fault/skip detection.
module hall_position_decoder
  import hall_position_decoder_pkg::*;
#(
  parameter int clk_freq_hz   = 27_000_000,
  parameter int counter_width = 32,
  parameter int period_width  = 24,
  parameter int filter_cycles = 4,
  parameter int idle_ms       = 100
) (
  input  logic                     sys_clk,
  input  logic                     reset_n,
  input  hall_states_t             hall_values,
  input  logic                     clear_fault,
  input  logic                     pos_load,
  input  logic [counter_width-1:0] pos_load_value,
  output logic [2:0]               sector,
  output rotation_direction_t      rotation_direction,
  output logic [counter_width-1:0] position,
  output logic                     step,
  output logic [period_width-1:0]  period,
  output logic                     period_valid,
  output logic                     stalled,
  output logic                     fault_invalid,
  output logic [7:0]               skip_count
);

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_STALLED = 2'd1,
    ST_RUNNING = 2'd2
  } state_t;

  localparam longint IDLE_TICKS = longint'(clk_freq_hz) / 1000 * longint'(idle_ms);
  localparam logic [period_width-1:0] IDLE_P = period_width'(IDLE_TICKS);
  localparam logic [period_width-1:0] PERIOD_UNKNOWN = '1;

  if (IDLE_TICKS >= (longint'(1) << period_width)) begin : g_chk_idle
    $error("hall_position_decoder: idle_ticks does not fit in period_width");
  end

  hall_states_t acc_code;
  logic         acc_changed;

  hall_input_filter #(
    .filter_cycles(filter_cycles)
  ) u_filter (
    .clk_i     (sys_clk),
    .rst_ni    (reset_n),
    .hall_i    (hall_values),
    .code_o    (acc_code),
    .changed_o (acc_changed)
  );

  state_t                   state_q, state_d;
  logic [2:0]               sector_q, sector_d;
  rotation_direction_t      dir_q, dir_d;
  logic [counter_width-1:0] pos_q, pos_d;
  logic                     step_q, step_d;
  logic [period_width-1:0]  period_q, period_d;
  logic                     pval_q, pval_d;
  logic                     stalled_q, stalled_d;
  logic                     fault_q, fault_d;
  logic [7:0]               skip_q, skip_d;
  logic [period_width-1:0]  pcnt_q, pcnt_d;

  logic [2:0]               new_sector;
  logic                     do_step;
  rotation_direction_t      step_dir;

  always_comb begin
    state_d    = state_q;
    sector_d   = sector_q;
    dir_d      = dir_q;
    pos_d      = pos_q;
    step_d     = 1'b0;
    period_d   = period_q;
    pval_d     = 1'b0;
    fault_d    = fault_q;
    skip_d     = skip_q;
    pcnt_d     = (pcnt_q == PERIOD_UNKNOWN) ? pcnt_q : pcnt_q + period_width'(1);
    new_sector = hall_to_sector(acc_code);
    do_step    = 1'b0;
    step_dir   = DIR_NONE;

    // Clearing comes first so an invalid code accepted in the same cycle keeps the fault set.
    if (clear_fault) fault_d = 1'b0;

    if (acc_changed) begin
      if (new_sector == SECTOR_UNKNOWN) begin
        sector_d = SECTOR_UNKNOWN;
        fault_d  = 1'b1;
        dir_d    = DIR_NONE;
        period_d = PERIOD_UNKNOWN;
        state_d  = ST_INIT;
      end else if (state_q == ST_INIT) begin
        sector_d = new_sector;
        dir_d    = DIR_NONE;
        state_d  = ST_STALLED;
      end else if (new_sector == next_sector(sector_q)) begin
        do_step  = 1'b1;
        step_dir = DIR_CW;
      end else if (new_sector == prev_sector(sector_q)) begin
        do_step  = 1'b1;
        step_dir = DIR_CCW;
      end else begin
        sector_d = new_sector;
        skip_d   = (skip_q == 8'hFF) ? skip_q : skip_q + 8'd1;
        dir_d    = DIR_NONE;
        period_d = PERIOD_UNKNOWN;
        pcnt_d   = period_width'(1);
        state_d  = ST_STALLED;
      end
    end else if (state_q == ST_RUNNING && pcnt_q >= IDLE_P) begin
      dir_d    = DIR_NONE;
      period_d = PERIOD_UNKNOWN;
      state_d  = ST_STALLED;
    end

    if (do_step) begin
      sector_d = new_sector;
      step_d   = 1'b1;
      dir_d    = step_dir;
      state_d  = ST_RUNNING;
      pcnt_d   = period_width'(1);
      pos_d    = (step_dir == DIR_CW) ? pos_q + counter_width'(1)
                                      : pos_q - counter_width'(1);
      // A period is only meaningful between two steps of the same running direction.
      if (state_q == ST_RUNNING && dir_q == step_dir) begin
        pval_d   = 1'b1;
        period_d = pcnt_q;
      end
    end

    if (pos_load) pos_d = pos_load_value;

    stalled_d = (state_d != ST_RUNNING);
  end

  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      state_q   <= ST_INIT;
      sector_q  <= SECTOR_UNKNOWN;
      dir_q     <= DIR_NONE;
      pos_q     <= '0;
      step_q    <= 1'b0;
      period_q  <= PERIOD_UNKNOWN;
      pval_q    <= 1'b0;
      stalled_q <= 1'b1;
      fault_q   <= 1'b0;
      skip_q    <= 8'd0;
      pcnt_q    <= PERIOD_UNKNOWN;
    end else begin
      state_q   <= state_d;
      sector_q  <= sector_d;
      dir_q     <= dir_d;
      pos_q     <= pos_d;
      step_q    <= step_d;
      period_q  <= period_d;
      pval_q    <= pval_d;
      stalled_q <= stalled_d;
      fault_q   <= fault_d;
      skip_q    <= skip_d;
      pcnt_q    <= pcnt_d;
    end
  end

  assign sector             = sector_q;
  assign rotation_direction = dir_q;
  assign position           = pos_q;
  assign step               = step_q;
  assign period             = period_q;
  assign period_valid       = pval_q;
  assign stalled            = stalled_q;
  assign fault_invalid      = fault_q;
  assign skip_count         = skip_q;

endmodule

// File: tb/tb_hall_position_decoder.sv
// Scoreboard bench for hall_position_decoder: directed Hall sequences, expected output changes queued.
module tb_hall_position_decoder;
  import hall_position_decoder_pkg::*;

  localparam int FILT = 4;
  localparam int IDLE = 3000;   // 1 MHz clock, 3 ms idle
  localparam int LAT  = 3 + FILT;
  localparam logic [23:0] P_UNK = 24'hFF_FFFF;

  logic                sys_clk = 1'b0;
  logic                reset_n = 1'b0;
  hall_states_t        hall_values = 3'b111;
  logic                clear_fault = 1'b0;
  logic                pos_load = 1'b0;
  logic [31:0]         pos_load_value = '0;
  logic [2:0]          sector;
  rotation_direction_t rotation_direction;
  logic [31:0]         position;
  logic                step;
  logic [23:0]         period;
  logic                period_valid;
  logic                stalled;
  logic                fault_invalid;
  logic [7:0]          skip_count;

  hall_position_decoder #(
    .clk_freq_hz   (1_000_000),
    .counter_width (32),
    .period_width  (24),
    .filter_cycles (FILT),
    .idle_ms       (3)
  ) dut (
    .sys_clk            (sys_clk),
    .reset_n            (reset_n),
    .hall_values        (hall_values),
    .clear_fault        (clear_fault),
    .pos_load           (pos_load),
    .pos_load_value     (pos_load_value),
    .sector             (sector),
    .rotation_direction (rotation_direction),
    .position           (position),
    .step               (step),
    .period             (period),
    .period_valid       (period_valid),
    .stalled            (stalled),
    .fault_invalid      (fault_invalid),
    .skip_count         (skip_count)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  typedef struct {
    int          t;
    logic [2:0]  sec;
    logic [1:0]  dir;
    logic [31:0] pos;
    logic        stp;
    logic [23:0] per;
    logic        pv;
    logic        st;
    logic        flt;
    logic [7:0]  sk;
  } obs_t;

  obs_t exp_q[$];
  logic mon_en = 1'b0;
  logic stim_done = 1'b0;
  int   n_checks = 0;
  int   n_fails = 0;
  int   k = 0;

  task automatic expect_obs(input int t, input logic [2:0] sec, input rotation_direction_t d,
                            input logic [31:0] pos, input logic stp, input logic [23:0] per,
                            input logic pv, input logic st, input logic flt, input logic [7:0] sk);
    obs_t o;
    o.t = t; o.sec = sec; o.dir = d; o.pos = pos; o.stp = stp;
    o.per = per; o.pv = pv; o.st = st; o.flt = flt; o.sk = sk;
    exp_q.push_back(o);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic apply(input hall_states_t code);
    hall_values = code;
    k = cyc;
  endtask

  // Monitor: every visible output change (or step/period_valid pulse) is one transaction.
  initial begin
    obs_t cur, last, e;
    int   idx;
    logic first;
    first = 1'b1;
    idx = 0;
    wait (mon_en);
    while (!stim_done) begin
      @(negedge sys_clk);
      cur.t = cyc; cur.sec = sector; cur.dir = rotation_direction; cur.pos = position;
      cur.stp = step; cur.per = period; cur.pv = period_valid; cur.st = stalled;
      cur.flt = fault_invalid; cur.sk = skip_count;
      if (first || cur.stp || cur.pv || cur.sec !== last.sec || cur.dir !== last.dir ||
          cur.pos !== last.pos || cur.per !== last.per || cur.st !== last.st ||
          cur.flt !== last.flt || cur.sk !== last.sk) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fails++;
          $display("FAIL unexpected_output txn%0d cyc=%0d sec=%0d dir=%0d pos=%0d step=%b per=%0d pv=%b st=%b flt=%b skip=%0d",
                   idx, cyc, cur.sec, cur.dir, $signed(cur.pos), cur.stp, cur.per, cur.pv, cur.st, cur.flt, cur.sk);
        end else begin
          e = exp_q.pop_front();
          if (cur.sec !== e.sec || cur.dir !== e.dir || cur.pos !== e.pos || cur.stp !== e.stp ||
              cur.per !== e.per || cur.pv !== e.pv || cur.st !== e.st || cur.flt !== e.flt ||
              cur.sk !== e.sk) begin
            n_fails++;
            $display("FAIL txn%0d_outputs got sec=%0d dir=%0d pos=%0d step=%b per=%0d pv=%b st=%b flt=%b skip=%0d exp sec=%0d dir=%0d pos=%0d step=%b per=%0d pv=%b st=%b flt=%b skip=%0d",
                     idx, cur.sec, cur.dir, $signed(cur.pos), cur.stp, cur.per, cur.pv, cur.st, cur.flt, cur.sk,
                     e.sec, e.dir, $signed(e.pos), e.stp, e.per, e.pv, e.st, e.flt, e.sk);
          end
          if (e.t >= 0) begin
            n_checks++;
            if (cyc != e.t) begin
              n_fails++;
              $display("FAIL txn%0d_timing got cyc=%0d exp cyc=%0d", idx, cyc, e.t);
            end
          end
        end
        idx++;
      end
      last = cur;
      first = 1'b0;
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_checks++;
      n_fails++;
      $display("FAIL missing_output got none exp sec=%0d pos=%0d at cyc=%0d", e.sec, $signed(e.pos), e.t);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    // Reset values
    expect_obs(-1, 3'd7, DIR_NONE, 32'd0, 1'b0, P_UNK, 1'b0, 1'b1, 1'b0, 8'd0);
    wait_cyc(3);
    mon_en = 1'b1;
    wait_cyc(2);
    reset_n = 1'b1;
    wait_cyc(20);

    // Seed sector 0, then a full CW revolution at 1000 cycles per sector
    apply(3'b101); expect_obs(k+LAT, 3'd0, DIR_NONE, 32'd0, 1'b0, P_UNK, 1'b0, 1'b1, 1'b0, 8'd0); wait_cyc(1000);
    apply(3'b100); expect_obs(k+LAT, 3'd1, DIR_CW, 32'd1, 1'b1, P_UNK, 1'b0, 1'b0, 1'b0, 8'd0); wait_cyc(1000);
    apply(3'b110); expect_obs(k+LAT, 3'd2, DIR_CW, 32'd2, 1'b1, 24'd1000, 1'b1, 1'b0, 1'b0, 8'd0); wait_cyc(1000);
    apply(3'b010); expect_obs(k+LAT, 3'd3, DIR_CW, 32'd3, 1'b1, 24'd1000, 1'b1, 1'b0, 1'b0, 8'd0); wait_cyc(1000);
    apply(3'b011); expect_obs(k+LAT, 3'd4, DIR_CW, 32'd4, 1'b1, 24'd1000, 1'b1, 1'b0, 1'b0, 8'd0); wait_cyc(1000);
    apply(3'b001); expect_obs(k+LAT, 3'd5, DIR_CW, 32'd5, 1'b1, 24'd1000, 1'b1, 1'b0, 1'b0, 8'd0); wait_cyc(1000);
    apply(3'b101); expect_obs(k+LAT, 3'd0, DIR_CW, 32'd6, 1'b1, 24'd1000, 1'b1, 1'b0, 1'b0, 8'd0); wait_cyc(1000);

    // Reversal: no period_valid, then a CCW step 500 cycles later measures 500
    apply(3'b001); expect_obs(k+LAT, 3'd5, DIR_CCW, 32'd5, 1'b1, 24'd1000, 1'b0, 1'b0, 1'b0, 8'd0); wait_cyc(500);
    apply(3'b011); expect_obs(k+LAT, 3'd4, DIR_CCW, 32'd4, 1'b1, 24'd500, 1'b1, 1'b0, 1'b0, 8'd0);
    // Stall after idle_ticks with no transition
    expect_obs(k+LAT+IDLE, 3'd4, DIR_NONE, 32'd4, 1'b0, P_UNK, 1'b0, 1'b1, 1'b0, 8'd0);
    wait_cyc(3100);

    // Load -5, held across a CW step: load wins, step still pulses
    pos_load_value = 32'hFFFF_FFFB;
    pos_load = 1'b1;
    expect_obs(cyc+1, 3'd4, DIR_NONE, 32'hFFFF_FFFB, 1'b0, P_UNK, 1'b0, 1'b1, 1'b0, 8'd0);
    wait_cyc(5);
    apply(3'b001); expect_obs(k+LAT, 3'd5, DIR_CW, 32'hFFFF_FFFB, 1'b1, P_UNK, 1'b0, 1'b0, 1'b0, 8'd0);
    wait_cyc(20);
    pos_load = 1'b0;
    wait_cyc(980);
    apply(3'b101); expect_obs(k+LAT, 3'd0, DIR_CW, 32'hFFFF_FFFC, 1'b1, 24'd1000, 1'b1, 1'b0, 1'b0, 8'd0); wait_cyc(1000);

    // Skip 0 -> 2
    apply(3'b110); expect_obs(k+LAT, 3'd2, DIR_NONE, 32'hFFFF_FFFC, 1'b0, P_UNK, 1'b0, 1'b1, 1'b0, 8'd1); wait_cyc(1000);

    // 2-cycle glitch on B: must produce nothing
    hall_values = 3'b100; wait_cyc(2);
    hall_values = 3'b110; wait_cyc(50);

    // Invalid 000, then clear_fault
    apply(3'b000); expect_obs(k+LAT, 3'd7, DIR_NONE, 32'hFFFF_FFFC, 1'b0, P_UNK, 1'b0, 1'b1, 1'b1, 8'd1); wait_cyc(50);
    clear_fault = 1'b1;
    expect_obs(cyc+1, 3'd7, DIR_NONE, 32'hFFFF_FFFC, 1'b0, P_UNK, 1'b0, 1'b1, 1'b0, 8'd1);
    wait_cyc(1);
    clear_fault = 1'b0;
    wait_cyc(50);

    // Invalid 111 accepted in the same cycle as clear_fault: fault stays set
    apply(3'b111); expect_obs(k+LAT, 3'd7, DIR_NONE, 32'hFFFF_FFFC, 1'b0, P_UNK, 1'b0, 1'b1, 1'b1, 8'd1);
    wait_cyc(LAT-1);
    clear_fault = 1'b1;
    wait_cyc(1);
    clear_fault = 1'b0;
    wait_cyc(50);

    // Re-seed from INIT without a step, then a CW step
    apply(3'b011); expect_obs(k+LAT, 3'd4, DIR_NONE, 32'hFFFF_FFFC, 1'b0, P_UNK, 1'b0, 1'b1, 1'b1, 8'd1); wait_cyc(100);
    apply(3'b001); expect_obs(k+LAT, 3'd5, DIR_CW, 32'hFFFF_FFFD, 1'b1, P_UNK, 1'b0, 1'b0, 1'b1, 8'd1); wait_cyc(30);

    // Reset mid-operation
    reset_n = 1'b0;
    hall_values = 3'b111;
    expect_obs(cyc+1, 3'd7, DIR_NONE, 32'd0, 1'b0, P_UNK, 1'b0, 1'b1, 1'b0, 8'd0);
    wait_cyc(3);
    reset_n = 1'b1;
    wait_cyc(50);

    stim_done = 1'b1;
  end

endmodule
